alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command front-end and result stage for the combinational 16-bit breadboard ALU.
//  - Accepts op/operand commands over a valid/ready handshake.
//  - Drives the ALU with {accumulator low half, operand, op_code}.
//  - Waits a fixed settle time, then captures the 32-bit ALU result into the accumulator.
//  - Returns the result and error status over a second valid/ready handshake.
//  - The ALU is instantiated beside this block at the top level, not inside it.
// PARAMETERS
//  WIDTH          16  operand width; also the width of the ALU inputs
//  RWIDTH         32  accumulator and result width; also the ALU output width
//  SETTLE_CYCLES  2   cycles the ALU inputs are held before capture; minimum 1
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       block can accept a command
//  cmd_op        in   4       0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 8 LOAD, 9 CLEAR; any other value is NOP
//  cmd_operand   in   WIDTH   signed operand
//  alu_input1    out  WIDTH   ALU input1 = acc[WIDTH-1:0]
//  alu_input2    out  WIDTH   ALU input2 = operand
//  alu_op_code   out  4       ALU op_code
//  alu_output1   in   RWIDTH  ALU result
//  alu_err_code  in   2       ALU error code; nonzero means error
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       consumer accepts the response
//  rsp_result    out  RWIDTH  accumulator value after the command
//  rsp_err       out  2       [0] ALU reported an error; [1] range error, op not issued
//  acc_value     out  RWIDTH  live accumulator
//  op_count      out  16      saturating count of completed ALU-issued ops
// BEHAVIOUR
//  Reset values
//  - rst_n low: every output is 0, acc = 0, op_count = 0, state = IDLE.
//  - Reset takes effect immediately, including mid-operation; the in-flight command is dropped.
//  States: IDLE, ISSUE, RESP.
//  - cmd_ready = (state == IDLE).
//  - Acceptance is the edge where cmd_valid && cmd_ready.
//  IDLE, on acceptance
//  - ALU ops 0..4 with acc representable as signed WIDTH (acc[RWIDTH-1:WIDTH-1] all equal):
//    register alu_input1, alu_input2 and alu_op_code; load settle counter = SETTLE_CYCLES-1; go to ISSUE.
//  - ALU op 0..4 with acc out of range: range error. rsp_err = 2'b10, acc unchanged, ALU ports unchanged; go to RESP.
//  - LOAD: acc = sign-extended operand; go to RESP.
//  - CLEAR: acc = 0; go to RESP.
//  - NOP: acc unchanged; go to RESP.
//  ISSUE
//  - ALU ports are held stable; the counter decrements each cycle.
//  - On the edge where the counter is 0, capture the result and go to RESP:
//    - alu_err_code == 0: acc = alu_output1, rsp_err = 0.
//    - alu_err_code != 0: acc unchanged, rsp_err = 2'b01.
//  - op_count increments on capture and saturates at 16'hFFFF; error captures also count.
//  RESP
//  - rsp_valid = 1; rsp_result = acc. Both are stable until rsp_valid && rsp_ready, then go to IDLE.
//  - Backpressure stalls indefinitely; no commands are accepted meanwhile.
//  Latency, acceptance edge to rsp_valid high
//  - ALU op: SETTLE_CYCLES + 1 cycles.
//  - LOAD, CLEAR, NOP, range error: 1 cycle.
//  Throughput
//  - One command is outstanding at a time.
//  - cmd_ready rises the cycle after the response handshake. No same-cycle response-to-command bypass.
//  Arithmetic
//  - The accumulator is two's complement RWIDTH.
//  - The block performs no arithmetic itself apart from sign extension and the op_count increment.
// STRUCTURE
//  Shared package alu_pkg:
//  - opcode localparams OP_ADD..OP_MOD, OP_LOAD, OP_CLEAR
//  - state enum {IDLE, ISSUE, RESP}
//  - rsp_err bit indices ERR_ALU = 0, ERR_RANGE = 1
//  Single module, no sub-module.
//  - Settle counter is $clog2(SETTLE_CYCLES+1) bits.
// TESTING
//  Bench instantiates this block with the breadboard ALU, SETTLE_CYCLES = 2, rsp_ready = 1 unless stated.
//  1. LOAD 11, then MUL 15 -> rsp_result 165, rsp_err 00; MUL response 3 cycles after acceptance; op_count 1.
//  2. After test 1, DIV 0 -> rsp_err 01, rsp_result 165, acc unchanged; op_count 2.
//  3. LOAD 32000, MUL 16000 -> 512000000. Then ADD 1 -> rsp_err 10, result 512000000, ALU ports unchanged, response after 1 cycle.
//  4. LOAD 16'hFFF9 (-7) -> acc 32'hFFFFFFF9. Then DIV 2 -> rsp_result -3 sign-extended to 32'hFFFFFFFD.
//  5. rsp_ready low for 5 cycles -> rsp_valid and rsp_result stable, cmd_ready 0 throughout; cmd_ready 1 the cycle after the handshake.
//  6. rst_n low in the middle of ISSUE -> all outputs 0 immediately, acc 0; next command accepted normally once rst_n is high.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and response error bit positions
// for the breadboard ALU command sequencer.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    localparam int ERR_ALU   = 0;
    localparam int ERR_RANGE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_MOD;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels of the ALU sequencer.
// master = command producer / response consumer, slave = sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int RWIDTH = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_operand;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RWIDTH-1:0] rsp_result;
    logic [1:0]        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end and result stage for the combinational 16-bit ALU:
// issues acc/operand to the ALU, waits a settle time, captures the result.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int RWIDTH        = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [3:0]         alu_op_code,
    input  logic [RWIDTH-1:0]  alu_output1,
    input  logic [1:0]         alu_err_code,
    output logic [RWIDTH-1:0]  acc_value,
    output logic [15:0]        op_count
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RWIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]  in1_q, in1_d;
    logic [WIDTH-1:0]  in2_q, in2_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       opc_q, opc_d;

    logic [RWIDTH-WIDTH:0] acc_hi;
    logic                  in_range;
    logic [RWIDTH-1:0]     operand_sx;

    // The ALU only sees the low half, so the upper bits must be pure sign
    assign acc_hi     = acc_q[RWIDTH-1:WIDTH-1];
    assign in_range   = (&acc_hi) | ~(|acc_hi);
    assign operand_sx = {{(RWIDTH-WIDTH){bus.cmd_operand[WIDTH-1]}},
                         bus.cmd_operand};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        err_d   = err_q;
        opc_d   = opc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    err_d   = '0;
                    state_d = RESP;
                    unique case (1'b1)
                        is_alu_op(bus.cmd_op): begin
                            if (in_range) begin
                                in1_d   = acc_q[WIDTH-1:0];
                                in2_d   = bus.cmd_operand;
                                op_d    = bus.cmd_op;
                                cnt_d   = CNT_LOAD;
                                state_d = ISSUE;
                            end else begin
                                err_d[ERR_RANGE] = 1'b1;
                            end
                        end
                        (bus.cmd_op == OP_LOAD):  acc_d = operand_sx;
                        (bus.cmd_op == OP_CLEAR): acc_d = '0;
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (alu_err_code == 2'b00) begin
                        acc_d = alu_output1;
                    end else begin
                        err_d[ERR_ALU] = 1'b1;
                    end
                    if (opc_q != 16'hFFFF) begin
                        opc_d = opc_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            err_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            err_q   <= err_d;
            opc_q   <= opc_d;
        end
    end

    // Gated with rst_n so that cmd_ready reads 0 while reset is held
    assign bus.cmd_ready  = rst_n && (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = acc_q;
    assign bus.rsp_err    = err_q;
    assign alu_input1     = in1_q;
    assign alu_input2     = in2_q;
    assign alu_op_code    = op_q;
    assign acc_value      = acc_q;
    assign op_count       = opc_q;

endmodule
